// File: rtl/instruction_prefetch_buffer_if.sv
// ============================================================================
// Module      : instruction_prefetch_buffer_if
// Description : Fetch-stage and instruction-memory signal bundle for the
//               sequential instruction prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_prefetch_buffer_if;
    logic        instruction_request_i;
    logic [31:0] instruction_addr_i;
    logic        flush_bus_i;
    logic        instruction_response_o;
    logic [31:0] instruction_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    // Prefetcher side
    modport slave (
        input  instruction_request_i,
        input  instruction_addr_i,
        input  flush_bus_i,
        output instruction_response_o,
        output instruction_data_o,
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_data_i
    );

    // Fetch-stage / memory side
    modport master (
        output instruction_request_i,
        output instruction_addr_i,
        output flush_bus_i,
        input  instruction_response_o,
        input  instruction_data_o,
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_data_i
    );
endinterface

`default_nettype wire

// File: rtl/instruction_prefetch_buffer.sv
// ============================================================================
// Module      : instruction_prefetch_buffer
// Description : Sequential instruction prefetcher with a DEPTH-entry tagged
//               FIFO answering the fetch stage from its head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_prefetch_buffer #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input wire                           clk,
    input wire                           rst,
    instruction_prefetch_buffer_if.slave bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          data_q [DEPTH];
    logic [29:0]          tag_q  [DEPTH];
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [29:0]          issue_tag_q, issue_tag_d;
    logic [29:0]          req_tag_q, req_tag_d;

    logic [29:0]          w_tag;
    logic [29:0]          w_head_tag;
    logic [29:0]          w_pend_tag;
    logic                 w_not_empty;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_advance;
    logic                 w_pending;
    logic                 w_redirect;
    logic                 w_push;
    logic [c_cnt_w-1:0]   w_count_after_pop;

    assign w_tag       = bus.instruction_addr_i[31:2];
    assign w_head_tag  = tag_q[rd_ptr_q];
    assign w_not_empty = (count_q != '0);
    assign w_req       = bus.instruction_request_i && !bus.flush_bus_i;

    // While a request is in flight, the stream position is the outstanding tag.
    assign w_pend_tag  = (state_q == ST_WAIT) ? req_tag_q : issue_tag_q;

    assign w_hit       = w_req && w_not_empty && (w_tag == w_head_tag);
    assign w_advance   = w_req && w_not_empty && (w_tag == (w_head_tag + 30'd1));
    assign w_pending   = w_req && !w_not_empty && (w_tag == w_pend_tag);
    assign w_redirect  = bus.instruction_request_i && !(w_hit || w_advance || w_pending);

    assign w_count_after_pop = count_q - c_cnt_w'(w_advance);

    assign bus.instruction_response_o = w_hit;
    assign bus.instruction_data_o     = w_hit ? data_q[rd_ptr_q] : 32'h0;
    assign bus.mem_req_o              = (state_q != ST_IDLE);
    assign bus.mem_addr_o             = {req_tag_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        issue_tag_d = issue_tag_q;
        req_tag_d   = req_tag_q;
        w_push      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_redirect) begin
                    issue_tag_d = w_tag;
                end else if (bus.instruction_request_i && (w_count_after_pop < c_depth)) begin
                    state_d     = ST_WAIT;
                    req_tag_d   = issue_tag_q;
                    issue_tag_d = issue_tag_q + 30'd1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ack_i) begin
                    state_d = ST_IDLE;
                    if (w_redirect) begin
                        issue_tag_d = w_tag;
                    end else begin
                        w_push = 1'b1;
                    end
                end else if (w_redirect) begin
                    // Bus transaction must still complete; its data is stale.
                    state_d     = ST_DISCARD;
                    issue_tag_d = w_tag;
                end
            end
            ST_DISCARD: begin
                if (w_redirect) begin
                    issue_tag_d = w_tag;
                end
                if (bus.mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_advance) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
            end
            count_d = w_count_after_pop + c_cnt_w'(w_push);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            issue_tag_q <= BOOT_ADDRESS[31:2];
            req_tag_q   <= BOOT_ADDRESS[31:2];
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            issue_tag_q <= issue_tag_d;
            req_tag_q   <= req_tag_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            data_q[wr_ptr_q] <= bus.mem_data_i;
            tag_q[wr_ptr_q]  <= req_tag_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_prefetch_buffer.sv
// ============================================================================
// Module      : tb_instruction_prefetch_buffer
// Description : Directed self-checking bench for instruction_prefetch_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_prefetch_buffer;

    logic clk;
    logic rst;
    logic mem_hold;
    logic stray_ack;
    int   mem_age;
    int   n_checks;
    int   n_pass;
    logic found;

    instruction_prefetch_buffer_if bus_if ();

    instruction_prefetch_buffer #(
        .BOOT_ADDRESS (32'h0000_0000),
        .DEPTH        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address a reads as a + 0x13, acked the cycle after request.
    always @(negedge clk) begin
        bus_if.mem_ack_i  = 1'b0;
        bus_if.mem_data_i = 32'h0;
        if (stray_ack) begin
            bus_if.mem_ack_i  = 1'b1;
            bus_if.mem_data_i = 32'hDEAD_BEEF;
        end else if (rst || !bus_if.mem_req_o) begin
            mem_age = 0;
        end else if (mem_age >= 1 && !mem_hold) begin
            bus_if.mem_ack_i  = 1'b1;
            bus_if.mem_data_i = bus_if.mem_addr_o + 32'h13;
            mem_age = 0;
        end else begin
            mem_age = mem_age + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input int max_cycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (bus_if.mem_req_o === 1'b1 && bus_if.mem_addr_o === addr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        mem_hold  = 1'b0;
        stray_ack = 1'b0;
        mem_age   = 0;
        rst       = 1'b1;
        bus_if.instruction_request_i = 1'b1;
        bus_if.instruction_addr_i    = 32'h0;
        bus_if.flush_bus_i           = 1'b0;

        // Reset state
        tick();
        tick();
        check_value("rst_mem_req",  {31'h0, bus_if.mem_req_o}, 32'h0);
        check_value("rst_mem_addr", bus_if.mem_addr_o, 32'h0);
        check_value("rst_resp",     {31'h0, bus_if.instruction_response_o}, 32'h0);
        check_value("rst_data",     bus_if.instruction_data_o, 32'h0);

        // Cold boot: cycle 0 after release
        rst = 1'b0;
        #1;
        check_value("c0_resp",    {31'h0, bus_if.instruction_response_o}, 32'h0);
        check_value("c0_mem_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        tick();
        check_value("c1_mem_req",  {31'h0, bus_if.mem_req_o}, 32'h1);
        check_value("c1_mem_addr", bus_if.mem_addr_o, 32'h0);
        tick();
        check_value("c2_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("c3_resp",    {31'h0, bus_if.instruction_response_o}, 32'h1);
        check_value("c3_data",    bus_if.instruction_data_o, 32'h13);
        check_value("c3_mem_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        tick();
        check_value("c4_mem_addr", bus_if.mem_addr_o, 32'h4);
        repeat (3) tick();
        check_value("c7_mem_addr", bus_if.mem_addr_o, 32'h8);
        repeat (3) tick();
        check_value("c10_mem_addr", bus_if.mem_addr_o, 32'hC);
        repeat (2) tick();
        check_value("full_mem_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        repeat (3) tick();
        check_value("full_hold_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        check_value("full_hold_data", bus_if.instruction_data_o, 32'h13);

        // Advance from word 0 to word 4, refill request 0x10
        bus_if.instruction_addr_i = 32'h4;
        #1;
        check_value("adv4_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("hit4_data",     bus_if.instruction_data_o, 32'h17);
        check_value("hit4_mem_req",  {31'h0, bus_if.mem_req_o}, 32'h1);
        check_value("hit4_mem_addr", bus_if.mem_addr_o, 32'h10);

        // Unaligned PC re-reads the head word, then advances
        tick();
        bus_if.instruction_addr_i = 32'h102;
        repeat (16) tick();
        check_value("s2_full_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check_value("s2_hit102_resp", {31'h0, bus_if.instruction_response_o}, 32'h1);
            check_value("s2_hit102_data", bus_if.instruction_data_o, 32'h113);
            tick();
        end
        bus_if.instruction_addr_i = 32'h104;
        #1;
        check_value("s2_adv_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("s2_hit104_data", bus_if.instruction_data_o, 32'h117);
        check_value("s2_req110",      bus_if.mem_addr_o, 32'h110);
        check_value("s2_req110_v",    {31'h0, bus_if.mem_req_o}, 32'h1);

        // Jump while waiting: 0x200 in flight, core moves to 0x400
        bus_if.instruction_addr_i = 32'h200;
        wait_req(32'h200, 12, found);
        mem_hold = 1'b1;
        check_value("s3_req200_seen", {31'h0, found}, 32'h1);
        tick();
        bus_if.instruction_addr_i = 32'h400;
        #1;
        check_value("s3_jump_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("s3_disc_req",  {31'h0, bus_if.mem_req_o}, 32'h1);
        check_value("s3_disc_addr", bus_if.mem_addr_o, 32'h200);
        mem_hold = 1'b0;
        tick();
        check_value("s3_idle_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        tick();
        check_value("s3_req400", bus_if.mem_addr_o, 32'h400);
        check_value("s3_req400_v", {31'h0, bus_if.mem_req_o}, 32'h1);
        repeat (2) tick();
        check_value("s3_hit400_data", bus_if.instruction_data_o, 32'h413);
        bus_if.instruction_addr_i = 32'h200;
        #1;
        check_value("s3_no200_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);

        // Redirect coincident with ack
        tick();
        bus_if.instruction_addr_i = 32'h500;
        wait_req(32'h500, 12, found);
        mem_hold = 1'b1;
        check_value("s4_req500_seen", {31'h0, found}, 32'h1);
        tick();
        bus_if.instruction_addr_i = 32'h600;
        mem_hold = 1'b0;
        tick();
        check_value("s4_idle_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        check_value("s4_idle_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("s4_req600",   bus_if.mem_addr_o, 32'h600);
        check_value("s4_req600_v", {31'h0, bus_if.mem_req_o}, 32'h1);
        repeat (2) tick();
        check_value("s4_hit600_data", bus_if.instruction_data_o, 32'h613);

        // Flush while the PC matches the head
        bus_if.flush_bus_i = 1'b1;
        #1;
        check_value("s5_flush_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        bus_if.flush_bus_i = 1'b0;
        #1;
        check_value("s5_empty_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        wait_req(32'h600, 6, found);
        check_value("s5_refetch600", {31'h0, found}, 32'h1);
        repeat (2) tick();
        check_value("s5_hit600_data", bus_if.instruction_data_o, 32'h613);

        // Tag wrap at the top of the address space
        tick();
        bus_if.instruction_addr_i = 32'hFFFF_FFF8;
        wait_req(32'hFFFF_FFF8, 12, found);
        check_value("s6_reqF8", {31'h0, found}, 32'h1);
        wait_req(32'hFFFF_FFFC, 6, found);
        check_value("s6_reqFC", {31'h0, found}, 32'h1);
        wait_req(32'h0000_0000, 6, found);
        check_value("s6_req00", {31'h0, found}, 32'h1);
        repeat (6) tick();
        check_value("s6_full_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        check_value("s6_hitF8_data", bus_if.instruction_data_o, 32'h0000_000B);
        bus_if.instruction_addr_i = 32'hFFFF_FFFC;
        #1;
        check_value("s6_advFC_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("s6_hitFC_data", bus_if.instruction_data_o, 32'h0000_000F);
        bus_if.instruction_addr_i = 32'h0;
        #1;
        check_value("s6_adv00_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        mem_hold = 1'b1;
        check_value("s6_hit00_data", bus_if.instruction_data_o, 32'h13);
        check_value("s6_wait_req",   {31'h0, bus_if.mem_req_o}, 32'h1);
        check_value("s6_wait_addr",  bus_if.mem_addr_o, 32'h8);

        // Async reset while waiting
        rst = 1'b1;
        #1;
        check_value("ar_mem_req",  {31'h0, bus_if.mem_req_o}, 32'h0);
        check_value("ar_mem_addr", bus_if.mem_addr_o, 32'h0);
        check_value("ar_resp",     {31'h0, bus_if.instruction_response_o}, 32'h0);
        check_value("ar_data",     bus_if.instruction_data_o, 32'h0);
        tick();
        mem_hold = 1'b0;
        bus_if.instruction_request_i = 1'b0;
        rst = 1'b0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        check_value("stray_mem_req", {31'h0, bus_if.mem_req_o}, 32'h0);
        bus_if.instruction_request_i = 1'b1;
        #1;
        check_value("stray_no_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        tick();
        check_value("boot_req",  {31'h0, bus_if.mem_req_o}, 32'h1);
        check_value("boot_addr", bus_if.mem_addr_o, 32'h0);
        repeat (2) tick();
        check_value("boot_hit_data", bus_if.instruction_data_o, 32'h13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
